dual_port_ram: RTL and testbench
================================

Name: dual_port_ram

Overview:
- Byte-addressed, dual-port synchronous RAM used as the core's instruction/data memory model.
- Port A is the instruction fetch port: 128-bit (16-byte) line reads, plus an optional 32-bit byte-enabled write.
- Port B is the data port: 32-bit read/write with byte enables.
- The storage array is a flat byte array named mem, reachable hierarchically so the wrapper can clear and preload firmware before simulation starts.

Parameters:
ADDR_WIDTH, 20, byte-address width; depth is 2**ADDR_WIDTH bytes (default 1 MiB).

Ports:
clk  input  1  clock; all activity on rising edge
rst  input  1  synchronous, active-high reset; clears read-data registers only
en_a_i  input  1  port A request enable
addr_a_i  input  ADDR_WIDTH  port A byte address
wdata_a_i  input  32  port A write data
rdata_a_o  output  128  port A read line (16 bytes, little-endian)
we_a_i  input  1  port A write enable (1 = write, 0 = read)
be_a_i  input  4  port A byte enables
en_b_i  input  1  port B request enable
addr_b_i  input  ADDR_WIDTH  port B byte address
wdata_b_i  input  32  port B write data
rdata_b_o  output  32  port B read data (little-endian)
we_b_i  input  1  port B write enable
be_b_i  input  4  port B byte enables

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Storage: reg [7:0] mem[0 : 2**ADDR_WIDTH-1].
  - No reset of contents and no initialisation inside the block; the wrapper owns clearing and loading.
- Port A addressing:
  - Line base = addr_a_i with bits [3:0] forced to 0.
  - Read returns mem[base+k] on rdata_a_o[8k+7:8k], for k = 0..15.
  - Write word address = addr_a_i with bits [1:0] forced to 0.
- Port B addressing:
  - Word address = addr_b_i with bits [1:0] forced to 0.
  - Byte k maps to bits [8k+7:8k], for k = 0..3.
- Read (en=1, we=0):
  - Registered output; data appears on rdata_x_o at the next rising edge (1-cycle latency), matching the wrapper's rvalid, which is registered from req.
- Write (en=1, we=1):
  - At the rising edge, mem[word+k] <= wdata[8k+7:8k] for each k with be[k]=1; bytes with be[k]=0 are untouched.
  - The output register is not updated on a write cycle (holds its previous value).
- Idle (en=0): no memory access; rdata_x_o holds its previous value indefinitely.
- Read-during-write semantics (read-first):
  - A read on one port of a byte written by the other port in the same cycle returns the old byte.
  - The new value is visible from the following cycle.
- Write collision: both ports write the same byte in the same cycle with both enables set -> port B's data wins.
- Reset (rst=1 at an edge):
  - rdata_a_o <= 0 and rdata_b_o <= 0, with priority over any read that cycle.
  - Writes presented during reset are still performed.
  - mem is untouched.
- Address wrap: addresses are ADDR_WIDTH bits, so no out-of-range access is possible; alignment masking keeps lines and words inside the array.
- No X propagation from the block itself: read-data registers power up to 0 in simulation.

Test Plan:
- Preload mem[0x80..0x8F] = 0x00..0x0F; port A read at addr 0x84 -> next cycle rdata_a_o = 0x0F0E0D0C_0B0A0908_07060504_03020100 (line-aligned to 0x80).
- Port B write addr 0x100, wdata 0xDEADBEEF, be 4'b1111; then read 0x102 -> rdata_b_o = 0xDEADBEEF one cycle after the read request.
- Byte enables: mem word 0x200 = 0x11223344; port B write wdata 0xAABBCCDD, be 4'b0101 -> readback 0x11BB33DD.
- Same cycle: port B writes 0xCAFEF00D to 0x90 while port A reads line 0x90 -> port A returns old bytes; a repeat read the next cycle shows 0xCAFEF00D in rdata_a_o[31:0].
- Both ports write byte 0x300 (A data 0x55, B data 0x66, be[0]=1) -> byte reads 0x66. With en low for 3 cycles, rdata outputs hold their last values.
- Assert rst for one edge after reads -> both rdata outputs read 0 on the next edge. A write issued during reset is visible on a subsequent read; preloaded mem contents are unchanged.

Source files
------------

// File: rtl/dual_port_ram.sv
// dual_port_ram: byte-addressed dual-port synchronous RAM.
// Port A fetches 16-byte lines and can also do a 32-bit byte-enabled write.
// Port B is a 32-bit byte-enabled read/write data port.
// Reads are read-first with 1-cycle latency. Port B wins write collisions.
// The storage array `mem` is left uninitialised here; the enclosing wrapper
// clears and preloads it hierarchically.
module dual_port_ram #(
  parameter int unsigned ADDR_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_a_i,
  input  logic [ADDR_WIDTH-1:0] addr_a_i,
  input  logic [31:0]           wdata_a_i,
  output logic [127:0]          rdata_a_o,
  input  logic                  we_a_i,
  input  logic [3:0]            be_a_i,
  input  logic                  en_b_i,
  input  logic [ADDR_WIDTH-1:0] addr_b_i,
  input  logic [31:0]           wdata_b_i,
  output logic [31:0]           rdata_b_o,
  input  logic                  we_b_i,
  input  logic [3:0]            be_b_i
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [7:0] mem [0:DEPTH-1];

  // Read-data registers power up to zero so the block never emits X.
  logic [127:0] r_rdata_a = '0;
  logic [31:0]  r_rdata_b = '0;

  logic w_rd_a;
  logic w_wr_a;
  logic w_rd_b;
  logic w_wr_b;

  assign w_rd_a = en_a_i & ~we_a_i;
  assign w_wr_a = en_a_i &  we_a_i;
  assign w_rd_b = en_b_i & ~we_b_i;
  assign w_wr_b = en_b_i &  we_b_i;

  // Byte-enabled writes from both ports. Writes still happen during reset.
  // Port B is assigned after port A so that on a same-byte collision its
  // non-blocking update is the one that lands.
  always_ff @(posedge clk) begin
    if (w_wr_a) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (be_a_i[k]) begin
          mem[{addr_a_i[ADDR_WIDTH-1:2], 2'(k)}] <= wdata_a_i[8*k +: 8];
        end
      end
    end
    if (w_wr_b) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (be_b_i[k]) begin
          mem[{addr_b_i[ADDR_WIDTH-1:2], 2'(k)}] <= wdata_b_i[8*k +: 8];
        end
      end
    end
  end

  // Port A line read: 16 bytes from the line-aligned base. Holds on write or idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata_a <= '0;
    end else if (w_rd_a) begin
      for (int unsigned k = 0; k < 16; k++) begin
        r_rdata_a[8*k +: 8] <= mem[{addr_a_i[ADDR_WIDTH-1:4], 4'(k)}];
      end
    end
  end

  // Port B word read: 4 bytes from the word-aligned address. Holds on write or idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata_b <= '0;
    end else if (w_rd_b) begin
      for (int unsigned k = 0; k < 4; k++) begin
        r_rdata_b[8*k +: 8] <= mem[{addr_b_i[ADDR_WIDTH-1:2], 2'(k)}];
      end
    end
  end

  assign rdata_a_o = r_rdata_a;
  assign rdata_b_o = r_rdata_b;

endmodule

// File: tb/tb_dual_port_ram.sv
// Self-checking bench for dual_port_ram.
// A byte-level reference model tracks every write issued through the ports.
// Each read pushes its expected result onto a per-port queue when it is
// issued. The queue is popped and compared one cycle later, when the
// registered output is valid.
module tb_dual_port_ram;

  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          en_a_i, we_a_i, en_b_i, we_b_i;
  logic [AW-1:0] addr_a_i, addr_b_i;
  logic [31:0]   wdata_a_i, wdata_b_i;
  logic [3:0]    be_a_i, be_b_i;
  logic [127:0]  rdata_a_o;
  logic [31:0]   rdata_b_o;

  int checks = 0;
  int errors = 0;

  logic [7:0]   model [int];
  logic [127:0] qa [$];
  logic [31:0]  qb [$];
  logic [127:0] last_a;
  logic [31:0]  last_b;

  dual_port_ram #(.ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en_a_i   (en_a_i),
    .addr_a_i (addr_a_i),
    .wdata_a_i(wdata_a_i),
    .rdata_a_o(rdata_a_o),
    .we_a_i   (we_a_i),
    .be_a_i   (be_a_i),
    .en_b_i   (en_b_i),
    .addr_b_i (addr_b_i),
    .wdata_b_i(wdata_b_i),
    .rdata_b_o(rdata_b_o),
    .we_b_i   (we_b_i),
    .be_b_i   (be_b_i)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en_a_i = 1'b0; we_a_i = 1'b0; addr_a_i = '0; wdata_a_i = '0; be_a_i = '0;
    en_b_i = 1'b0; we_b_i = 1'b0; addr_b_i = '0; wdata_b_i = '0; be_b_i = '0;
  endtask

  function automatic logic [127:0] model_line(input int addr);
    logic [127:0] l;
    int base;
    base = addr & ~15;
    for (int k = 0; k < 16; k++) begin
      l[8*k +: 8] = model.exists(base + k) ? model[base + k] : 8'h00;
    end
    return l;
  endfunction

  function automatic logic [31:0] model_word(input int addr);
    logic [31:0] w;
    int base;
    base = addr & ~3;
    for (int k = 0; k < 4; k++) begin
      w[8*k +: 8] = model.exists(base + k) ? model[base + k] : 8'h00;
    end
    return w;
  endfunction

  function automatic void model_write(input int addr, input logic [31:0] d,
                                      input logic [3:0] be);
    for (int k = 0; k < 4; k++) begin
      if (be[k]) model[(addr & ~3) + k] = d[8*k +: 8];
    end
  endfunction

  // Drive port stimulus for the coming edge.
  // Read expectations are captured before the model sees this cycle's writes.
  // Model writes are applied A first, then B, because port B wins collisions.
  task automatic drive_a_rd(input int addr);
    en_a_i = 1'b1; we_a_i = 1'b0; addr_a_i = AW'(addr);
    qa.push_back(model_line(addr));
  endtask

  task automatic drive_b_rd(input int addr);
    en_b_i = 1'b1; we_b_i = 1'b0; addr_b_i = AW'(addr);
    qb.push_back(model_word(addr));
  endtask

  task automatic drive_a_wr(input int addr, input logic [31:0] d, input logic [3:0] be);
    en_a_i = 1'b1; we_a_i = 1'b1; addr_a_i = AW'(addr); wdata_a_i = d; be_a_i = be;
  endtask

  task automatic drive_b_wr(input int addr, input logic [31:0] d, input logic [3:0] be);
    en_b_i = 1'b1; we_b_i = 1'b1; addr_b_i = AW'(addr); wdata_b_i = d; be_b_i = be;
  endtask

  task automatic commit_writes();
    if (en_a_i && we_a_i) model_write(int'(addr_a_i), wdata_a_i, be_a_i);
    if (en_b_i && we_b_i) model_write(int'(addr_b_i), wdata_b_i, be_b_i);
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (rdata_a_o !== 128'h0) begin
      errors++; $display("FAIL reset_a got %h exp %h", rdata_a_o, 128'h0);
    end
    checks++;
    if (rdata_b_o !== 32'h0) begin
      errors++; $display("FAIL reset_b got %h exp %h", rdata_b_o, 32'h0);
    end
    last_a = '0; last_b = '0;
  endtask

  task automatic test_line_read();
    logic [127:0] exp_a;
    // Preload 0x80..0x8F = 0x00..0x0F and 0x90..0x9F = 0x90..0x9F via port B.
    for (int i = 0; i < 8; i++) begin
      int base;
      base = 'h80 + 4 * i;
      idle();
      drive_b_wr(base, {8'(base + 3 - 'h80 * (i < 4 ? 1 : 0)), 8'(base + 2 - 'h80 * (i < 4 ? 1 : 0)),
                        8'(base + 1 - 'h80 * (i < 4 ? 1 : 0)), 8'(base - 'h80 * (i < 4 ? 1 : 0))},
                 4'b1111);
      commit_writes();
      tick();
    end
    idle();
    drive_a_rd('h84);
    tick();
    idle();
    exp_a = qa.pop_front();
    checks++;
    if (exp_a !== 128'h0F0E0D0C_0B0A0908_07060504_03020100) begin
      errors++; $display("FAIL line_model got %h exp %h", exp_a, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
    end
    checks++;
    if (rdata_a_o !== 128'h0F0E0D0C_0B0A0908_07060504_03020100) begin
      errors++; $display("FAIL line_read got %h exp %h", rdata_a_o, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
    end
    last_a = rdata_a_o;
  endtask

  task automatic test_word_rw();
    logic [31:0] exp_b;
    idle();
    drive_b_wr('h100, 32'hDEADBEEF, 4'b1111);
    commit_writes();
    tick();
    checks++;
    if (rdata_b_o !== last_b) begin
      errors++; $display("FAIL write_hold_b got %h exp %h", rdata_b_o, last_b);
    end
    idle();
    drive_b_rd('h102);
    tick();
    idle();
    exp_b = qb.pop_front();
    checks++;
    if (rdata_b_o !== 32'hDEADBEEF || exp_b !== 32'hDEADBEEF) begin
      errors++; $display("FAIL word_rw got %h exp %h", rdata_b_o, 32'hDEADBEEF);
    end
    last_b = rdata_b_o;
  endtask

  task automatic test_byte_enable();
    idle();
    drive_b_wr('h200, 32'h11223344, 4'b1111);
    commit_writes();
    tick();
    idle();
    drive_b_wr('h200, 32'hAABBCCDD, 4'b0101);
    commit_writes();
    tick();
    idle();
    drive_b_rd('h200);
    tick();
    idle();
    void'(qb.pop_front());
    checks++;
    if (rdata_b_o !== 32'h11BB33DD) begin
      errors++; $display("FAIL byte_enable got %h exp %h", rdata_b_o, 32'h11BB33DD);
    end
    last_b = rdata_b_o;
  endtask

  task automatic test_read_during_write();
    logic [127:0] exp_a;
    idle();
    drive_a_rd('h90);
    drive_b_wr('h90, 32'hCAFEF00D, 4'b1111);
    commit_writes();
    tick();
    idle();
    exp_a = qa.pop_front();
    checks++;
    if (rdata_a_o !== exp_a || rdata_a_o[31:0] !== 32'h93929190) begin
      errors++; $display("FAIL rdw_old got %h exp %h", rdata_a_o, exp_a);
    end
    drive_a_rd('h9C);
    tick();
    idle();
    exp_a = qa.pop_front();
    checks++;
    if (rdata_a_o !== exp_a || rdata_a_o[31:0] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL rdw_new got %h exp %h", rdata_a_o, exp_a);
    end
    last_a = rdata_a_o;
  endtask

  task automatic test_collision();
    logic [31:0] exp_b;
    idle();
    drive_b_wr('h300, 32'h0, 4'b1111);
    commit_writes();
    tick();
    idle();
    // A writes bytes 0 and 1; B writes byte 0 only. Byte 0 must come from B.
    drive_a_wr('h300, 32'h00007755, 4'b0011);
    drive_b_wr('h301, 32'h00000066, 4'b0001);
    commit_writes();
    tick();
    idle();
    drive_b_rd('h300);
    tick();
    idle();
    exp_b = qb.pop_front();
    checks++;
    if (rdata_b_o !== 32'h00007766 || exp_b !== 32'h00007766) begin
      errors++; $display("FAIL collision got %h exp %h", rdata_b_o, 32'h00007766);
    end
    last_b = rdata_b_o;
    last_a = rdata_a_o;
    // Both ports idle for three cycles: outputs hold.
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (rdata_a_o !== last_a || rdata_b_o !== last_b) begin
        errors++; $display("FAIL idle_hold cyc %0d got %h/%h exp %h/%h",
                           c, rdata_a_o, rdata_b_o, last_a, last_b);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0]  eb;
    logic [127:0] ea;
    int addrs [4] = '{'h100, 'h200, 'h300, 'h90};
    for (int i = 0; i < 4; i++) begin
      idle();
      drive_b_rd(addrs[i] + i % 4);
      drive_a_rd(addrs[3 - i]);
      tick();
      eb = qb.pop_front();
      ea = qa.pop_front();
      checks++;
      if (rdata_b_o !== eb) begin
        errors++; $display("FAIL b2b_b %0d got %h exp %h", i, rdata_b_o, eb);
      end
      checks++;
      if (rdata_a_o !== ea) begin
        errors++; $display("FAIL b2b_a %0d got %h exp %h", i, rdata_a_o, ea);
      end
    end
    idle();
  endtask

  task automatic test_reset_clear();
    idle();
    drive_a_rd('h80);
    drive_b_rd('h100);
    tick();
    void'(qa.pop_front());
    void'(qb.pop_front());
    // Reset edge with a pending read on A and a write on B.
    idle();
    rst = 1'b1;
    en_a_i = 1'b1; we_a_i = 1'b0; addr_a_i = AW'('h80);
    drive_b_wr('h400, 32'h0BADC0DE, 4'b1111);
    commit_writes();
    tick();
    rst = 1'b0;
    idle();
    checks++;
    if (rdata_a_o !== 128'h0 || rdata_b_o !== 32'h0) begin
      errors++; $display("FAIL rst_clear got %h/%h exp 0/0", rdata_a_o, rdata_b_o);
    end
    drive_b_rd('h400);
    drive_a_rd('h80);
    tick();
    idle();
    void'(qb.pop_front());
    void'(qa.pop_front());
    checks++;
    if (rdata_b_o !== 32'h0BADC0DE) begin
      errors++; $display("FAIL rst_write got %h exp %h", rdata_b_o, 32'h0BADC0DE);
    end
    checks++;
    if (rdata_a_o !== 128'h0F0E0D0C_0B0A0908_07060504_03020100) begin
      errors++; $display("FAIL rst_mem_kept got %h exp %h", rdata_a_o, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
    end
  endtask

  initial begin
    idle();
    rst = 1'b0;
    #2;
    test_reset();
    test_line_read();
    test_word_rw();
    test_byte_enable();
    test_read_during_write();
    test_collision();
    test_back_to_back();
    test_reset_clear();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule
